z3_neuron: RTL and testbench
============================

Name: z3_neuron

Overview:
- Output-layer pre-activation neuron of the backpropagation network.
- Computes z3 = a2_1·w3_1 + a2_2·w3_2 + a2_3·w3_3 + b3 from three hidden-layer activations, three weights and one bias.
- All inputs are signed Q8.24; the result is registered and presented as a signed 8-bit Q4.4 value to the downstream activation/error logic.

Parameters:
- DATA_W, 32, width of activations, weights and bias (two's complement).
- DATA_FRAC, 24, fractional bits of inputs (1.0 = 0x01000000).
- OUT_W, 8, width of z3 output.
- OUT_FRAC, 4, fractional bits of z3 (1.0 = 0x10).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- a2_1, a2_2, a2_3, input, 32 each, signed Q8.24 hidden-layer activations.
- w3_1, w3_2, w3_3, input, 32 each, signed Q8.24 weights.
- b3, input, 32, signed Q8.24 bias.
- z3, output, 8, signed Q4.4 weighted sum, registered.

Behaviour:
- Reset: reset=0 clears z3 to 0x00 immediately, independent of clk. It is held at 0x00 while reset is low. Reset asserted mid-operation discards the in-flight result.
- Datapath is combinational from inputs to a single output register. Latency is 1 clock: z3 reflects the inputs sampled at the preceding rising edge. Throughput is one new operand set per clock.
- There is no handshake. Inputs are sampled every rising edge with reset high.
- Products: each a2_i·w3_i is a full 64-bit signed multiply (Q16.48). It is rescaled to Q8.24 by taking bits [55:24]. This is an arithmetic truncation, i.e. floor toward −∞.
- Sum: the three rescaled products and b3 are sign-extended to 34 bits (2 guard bits), so the accumulation itself never overflows.
- Output conversion: Q8.24 → Q4.4 by dropping the 20 LSBs (floor). Sum bits [27:20] form z3. There is no rounding.
- Range: representable z3 is −8.0 (0x80) to +7.9375 (0x7F). Out-of-range handling is selected by the optional feature.
- Overflow in the product rescale (|product| ≥ 128) is not detected. Callers keep operands within |a·w| < 128.

Optional Feature:
- Macro: Z3_SAT_EN.
- Defined: if the 34-bit sum exceeds +7.9375 or is below −8.0, z3 saturates to 0x7F or 0x80 respectively.
- Undefined: z3 is the plain bit slice [27:20] of the sum, which wraps modulo 16.0.
- In-range results are identical in both builds.

Decomposition:
- Package z3_pkg holds DATA_W, DATA_FRAC, OUT_W, OUT_FRAC, the derived slice positions (PROD_HI=55, PROD_LO=24, OUT_HI=27, OUT_LO=20), SUM_W=34, and the Q4.4 saturation constants 0x7F/0x80.
- One sub-module, fxp_mul_q824: signed 32×32 multiply returning the truncated Q8.24 result. It is instantiated three times.

Test Plan:
- Reset: drive reset=0 with arbitrary inputs, no clock edge → z3=0x00 immediately. Release reset, then one edge later z3 follows the inputs.
- Set A: a2=(0x00F31D88, 0x00FED1E8, 0x00FD5B22), w3=(0x00B33333, 0x00333333, 0x014CCCCC), b3=0xFF000000 → z3=0x12 (1.125) one cycle later. Then change only w3 to (0x00333333, 0x00800000, 0x01199999) → z3=0x0C (0.75) the next cycle.
- Set B, back-to-back streaming:
  - a2=(0x00DA1994, 0x00FACB80, 0x00FC6653) with weights 0.7/0.2/1.3 → 0x11, then with weights 0.2/0.5/1.1 → 0x0B.
  - a2=(0x00CED D7E, …) written contiguously as a2=(0x00CEDD7E, 0x00F31D88, 0x00EB6DB1) → 0x0F, then 0x0A.
  - Verifies 1-cycle latency with no bubbles.
- Negative/floor: all a2 and w3 = 0, b3=0xFF000000 → z3=0xF0 (−1.0). Next, b3=0xFFF00001 → z3=0xFF (floor of −0.0625+ε gives −0.0625).
- Overflow: a2_1=0x7F000000, w3_1=0x01000000, all others 0 → z3=0x7F with Z3_SAT_EN, 0xF0 without. a2_1=0x81000000, w3_1=0x01000000 → z3=0x80 with Z3_SAT_EN.

Source files
------------

// File: rtl/z3_pkg.sv
// z3_pkg: shared widths, slice positions and Q4.4 limits for the z3 neuron.
package z3_pkg;
    localparam int DATA_W    = 32;
    localparam int DATA_FRAC = 24;
    localparam int OUT_W     = 8;
    localparam int OUT_FRAC  = 4;
    localparam int PROD_HI   = DATA_FRAC + DATA_W - 1;
    localparam int PROD_LO   = DATA_FRAC;
    localparam int OUT_LO    = DATA_FRAC - OUT_FRAC;
    localparam int OUT_HI    = OUT_LO + OUT_W - 1;
    localparam int SUM_W     = DATA_W + 2;
    localparam logic signed [OUT_W-1:0] Z_MAX = 8'sh7F;
    localparam logic signed [OUT_W-1:0] Z_MIN = 8'sh80;
endpackage

// File: rtl/z3_neuron_fxp_mul_q824.sv
// fxp_mul_q824: signed Q8.24 multiply, product floored back to Q8.24 (bits [55:24]).
module fxp_mul_q824
    import z3_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_p
);
    // Arithmetic shift floors toward -inf; upper bits beyond PROD_HI are dropped unchecked.
    assign o_p = DATA_W'((64'(i_a) * 64'(i_b)) >>> PROD_LO);
endmodule

// File: rtl/z3_neuron.sv
// z3_neuron: registered z3 = sum(a2_i*w3_i) + b3, Q8.24 in, Q4.4 out.
// Define Z3_SAT_EN to saturate out-of-range results instead of wrapping.
module z3_neuron
    import z3_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] a2_1,
    input  logic signed [DATA_W-1:0] a2_2,
    input  logic signed [DATA_W-1:0] a2_3,
    input  logic signed [DATA_W-1:0] w3_1,
    input  logic signed [DATA_W-1:0] w3_2,
    input  logic signed [DATA_W-1:0] w3_3,
    input  logic signed [DATA_W-1:0] b3,
    output logic signed [OUT_W-1:0]  z3
);
    logic signed [DATA_W-1:0] w_p1, w_p2, w_p3;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [OUT_W-1:0]  w_z;
    logic signed [OUT_W-1:0]  r_z3;

    fxp_mul_q824 u_mul1 (.i_a(a2_1), .i_b(w3_1), .o_p(w_p1));
    fxp_mul_q824 u_mul2 (.i_a(a2_2), .i_b(w3_2), .o_p(w_p2));
    fxp_mul_q824 u_mul3 (.i_a(a2_3), .i_b(w3_3), .o_p(w_p3));

    assign w_sum = SUM_W'(w_p1) + SUM_W'(w_p2) + SUM_W'(w_p3) + SUM_W'(b3);

`ifdef Z3_SAT_EN
    logic signed [SUM_W-1:0] w_sh;
    assign w_sh = w_sum >>> OUT_LO;
    assign w_z  = (w_sh > SUM_W'(Z_MAX)) ? Z_MAX :
                  (w_sh < SUM_W'(Z_MIN)) ? Z_MIN : OUT_W'(w_sh);
`else
    assign w_z = OUT_W'(w_sum >>> OUT_LO);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_z3 <= '0;
        else        r_z3 <= w_z;
    end

    assign z3 = r_z3;
endmodule

// File: tb/tb_z3_neuron.sv
// tb_z3_neuron: directed vectors plus randomized operands checked against a longint model.
module tb_z3_neuron;
    import z3_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [31:0] a [3];
    logic signed [31:0] w [3];
    logic signed [31:0] b;
    logic signed [7:0]  z3;
    int n_tests = 0;
    int n_fail  = 0;

    z3_neuron dut (
        .clk(clk), .reset(reset),
        .a2_1(a[0]), .a2_2(a[1]), .a2_3(a[2]),
        .w3_1(w[0]), .w3_2(w[1]), .w3_3(w[2]),
        .b3(b), .z3(z3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Real-number semantics in integer form: floor each product to Q8.24, sum exactly, floor to Q4.4.
    function automatic logic [7:0] model();
        longint s = longint'(b);
        longint q;
        for (int i = 0; i < 3; i++) begin
            longint p = (longint'(a[i]) * longint'(w[i])) >>> 24;
            s += longint'(int'(p));
        end
        q = s >>> 20;
`ifdef Z3_SAT_EN
        if (q > 127)  return 8'h7F;
        if (q < -128) return 8'h80;
`endif
        return 8'(q);
    endfunction

    task automatic drive(input logic [31:0] a1, a2, a3, w1, w2, w3, bb);
        a[0] = a1; a[1] = a2; a[2] = a3;
        w[0] = w1; w[1] = w2; w[2] = w3;
        b = bb;
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        check(tag, z3, exp);
    endtask

    initial begin
        drive(32'h00F31D88, 32'h00FED1E8, 32'h00FD5B22, 32'h00B33333, 32'h00333333, 32'h014CCCCC, 32'hFF000000);
        step("pre_reset", 8'h12);
        #2 reset = 1'b0;
        #1 check("reset_async", z3, 8'h00);
        step("reset_held", 8'h00);
        #2 reset = 1'b1;
        step("reset_release", 8'h12);
        drive(32'h00F31D88, 32'h00FED1E8, 32'h00FD5B22, 32'h00333333, 32'h00800000, 32'h01199999, 32'hFF000000);
        step("setA_w2", 8'h0C);
        drive(32'h00DA1994, 32'h00FACB80, 32'h00FC6653, 32'h00B33333, 32'h00333333, 32'h014CCCCC, 32'hFF000000);
        step("setB1_w1", 8'h11);
        drive(32'h00DA1994, 32'h00FACB80, 32'h00FC6653, 32'h00333333, 32'h00800000, 32'h01199999, 32'hFF000000);
        step("setB1_w2", 8'h0B);
        drive(32'h00CEDD7E, 32'h00F31D88, 32'h00EB6DB1, 32'h00B33333, 32'h00333333, 32'h014CCCCC, 32'hFF000000);
        step("setB2_w1", 8'h0F);
        drive(32'h00CEDD7E, 32'h00F31D88, 32'h00EB6DB1, 32'h00333333, 32'h00800000, 32'h01199999, 32'hFF000000);
        step("setB2_w2", 8'h0A);
        drive(0, 0, 0, 0, 0, 0, 32'hFF000000);
        step("neg_one", 8'hF0);
        drive(0, 0, 0, 0, 0, 0, 32'hFFF00001);
        step("floor_neg", 8'hFF);
        drive(32'h7F000000, 0, 0, 32'h01000000, 0, 0, 0);
`ifdef Z3_SAT_EN
        step("ovf_pos", 8'h7F);
`else
        step("ovf_pos", 8'hF0);
`endif
        drive(32'h81000000, 0, 0, 32'h01000000, 0, 0, 0);
`ifdef Z3_SAT_EN
        step("ovf_neg", 8'h80);
`else
        step("ovf_neg", 8'h10);
`endif
        // Operands within +-4.0 keep |a*w| < 16; bias within +-16.0 exercises out-of-range sums.
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 3; k++) begin
                a[k] = $signed($urandom_range(0, 32'h07FFFFFF)) - 32'sh04000000;
                w[k] = $signed($urandom_range(0, 32'h07FFFFFF)) - 32'sh04000000;
            end
            b = $signed($urandom_range(0, 32'h1FFFFFFF)) - 32'sh10000000;
            step("random", model());
        end
        drive(32'h01000000, 0, 0, 32'h02000000, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("reset_midop", z3, 8'h00);
        #2 reset = 1'b1;
        step("after_midop", 8'h20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
